// File: rtl/axi_pkg.sv
// Shared AXI types and limits for the DMA read/write splitters.
package axi_pkg;

    localparam int AXI_4K_BYTES  = 4096;
    localparam int AXI_MAX_BEATS = 256;

    typedef logic [63:0] addr_64_t;
    typedef logic [31:0] addr_32_t;

    // len is the beat count (1..256); the AW driver subtracts one for awlen.
    typedef struct packed {
        addr_64_t   addr;
        logic [8:0] len;
    } trans_64_t;

    typedef struct packed {
        addr_32_t   addr;
        logic [8:0] len;
    } trans_32_t;

endpackage

// File: rtl/mo_wr_fifo_pkg.sv
// Local types for the write-side outstanding-burst FIFO.
package mo_wr_fifo_pkg;

    typedef enum logic {
        WR_IDLE  = 1'b0,
        WR_SPLIT = 1'b1
    } wr_state_e;

endpackage

// File: rtl/burst_split_calc.sv
// Combinational burst sizing: the next burst stops at the 4KB boundary,
// at the 256-beat limit, or at the end of the request, whichever is first.
module burst_split_calc
    import axi_pkg::*;
#(
    parameter int BEAT_SHIFT = 5
) (
    input  logic [11:0] addr_lo,
    input  logic [31:0] remaining,
    output logic [12:0] burst_bytes,
    output logic [8:0]  burst_beats
);

    localparam logic [31:0] MAX_BURST_BYTES = 32'(AXI_MAX_BEATS) << BEAT_SHIFT;

    logic [12:0] boundary_remaining;
    logic [12:0] raw_bytes;

    // Clamp remaining bytes to the 4KB page, then to the 256-beat cap.
    always_comb begin
        boundary_remaining = 13'(AXI_4K_BYTES) - {1'b0, addr_lo};
        raw_bytes = (remaining < {19'd0, boundary_remaining}) ? remaining[12:0]
                                                               : boundary_remaining;
        burst_bytes = ({19'd0, raw_bytes} > MAX_BURST_BYTES) ? 13'(MAX_BURST_BYTES)
                                                             : raw_bytes;
        burst_beats = 9'(burst_bytes >> BEAT_SHIFT);
    end

endmodule

// File: rtl/mo_wr_fifo.sv
// Write request splitter plus circular outstanding-burst FIFO with three
// consumer pointers: AW issue, W beat counting/wlast, and B completion.
module mo_wr_fifo
    import axi_pkg::*;
    import mo_wr_fifo_pkg::*;
#(
    parameter int  NUM_MO_BUF = 4,
    parameter int  ADDR_WIDTH = 64,
    parameter int  DATA_WIDTH = 256,
    parameter type addr_t     = axi_pkg::addr_64_t,
    parameter type trans_t    = axi_pkg::trans_64_t
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_valid,
    output logic        start_ready,
    input  addr_t       start_addr,
    input  logic [31:0] len,
    output logic        mo_fifo_full,
    output logic        mo_fifo_empty,
    output trans_t      fifo_mo_aw,
    output logic        fifo_mo_aw_valid,
    input  logic        fifo_mo_aw_ready,
    output trans_t      fifo_mo_w,
    output logic        fifo_mo_w_valid,
    input  logic        w_beat,
    output logic        w_last,
    input  logic        b_done,
    input  logic        b_err,
    output logic        wr_err,
    output logic        wr_busy
);

    localparam int SLOTS      = NUM_MO_BUF + 1;
    localparam int PTR_W      = $clog2(SLOTS);
    localparam int BEAT_SHIFT = $clog2(DATA_WIDTH / 8);

    typedef logic [PTR_W-1:0] ptr_t;

    // The FIFO has one spare slot so that full and empty are distinguishable.
    function automatic ptr_t ptr_next(input ptr_t p);
        return (p == ptr_t'(NUM_MO_BUF)) ? '0 : p + ptr_t'(1);
    endfunction

    wr_state_e             state;
    wr_state_e             next_state;
    ptr_t                  head;
    ptr_t                  aw_ptr;
    ptr_t                  w_ptr;
    ptr_t                  b_ptr;
    logic [8:0]            w_beat_cnt;
    logic [31:0]           remaining;
    logic [ADDR_WIDTH-1:0] current_addr;
    trans_t                fifo_mem [SLOTS];

    logic [12:0] split_bytes;
    logic [8:0]  split_beats;
    logic        start_fire;
    logic        push;
    logic        aw_pop;
    logic        w_ok;
    logic        b_ok;

    burst_split_calc #(
        .BEAT_SHIFT (BEAT_SHIFT)
    ) u_split (
        .addr_lo     (current_addr[11:0]),
        .remaining   (remaining),
        .burst_bytes (split_bytes),
        .burst_beats (split_beats)
    );

    assign mo_fifo_full     = (ptr_next(head) == b_ptr);
    assign mo_fifo_empty    = (head == b_ptr);
    assign start_ready      = (state == WR_IDLE) && !mo_fifo_full;
    assign start_fire       = start_valid && start_ready;
    assign push             = (state == WR_SPLIT) && (remaining != '0) && !mo_fifo_full;

    assign fifo_mo_aw       = fifo_mem[aw_ptr];
    assign fifo_mo_aw_valid = (aw_ptr != head);
    assign aw_pop           = fifo_mo_aw_valid && fifo_mo_aw_ready;

    assign fifo_mo_w        = fifo_mem[w_ptr];
    assign fifo_mo_w_valid  = (w_ptr != head);
    assign w_last           = fifo_mo_w_valid && (w_beat_cnt == 9'(fifo_mo_w.len - 9'd1));
    assign w_ok             = w_beat && fifo_mo_w_valid;

    // A response only frees a slot whose address and data have both gone out.
    assign b_ok             = b_done && (b_ptr != w_ptr) && (b_ptr != aw_ptr);

    assign wr_busy          = (state != WR_IDLE) || !mo_fifo_empty;

    // State register for the request splitter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WR_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Accept a request when idle; leave SPLIT once all bytes have been queued.
    always_comb begin
        next_state = state;
        case (state)
            WR_IDLE:  if (start_fire) next_state = WR_SPLIT;
            WR_SPLIT: if (remaining == '0) next_state = WR_IDLE;
            default:  next_state = WR_IDLE;
        endcase
    end

    // Latch the request, then walk address/remaining forward one burst per push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            current_addr <= '0;
            remaining    <= '0;
        end else if (start_fire) begin
            current_addr <= ADDR_WIDTH'(start_addr);
            remaining    <= len;
        end else if (push) begin
            current_addr <= current_addr + ADDR_WIDTH'(split_bytes);
            remaining    <= remaining - 32'(split_bytes);
        end
    end

    // Descriptor storage: written at head on push, cleared when B frees the slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (b_ok) begin
                fifo_mem[b_ptr] <= '0;
            end
            if (push) begin
                fifo_mem[head].addr <= current_addr;
                fifo_mem[head].len  <= split_beats;
            end
        end
    end

    // Producer pointer advances on every push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
        end else if (push) begin
            head <= ptr_next(head);
        end
    end

    // Consumer pointers move independently; W counts beats to find wlast.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_ptr     <= '0;
            w_ptr      <= '0;
            b_ptr      <= '0;
            w_beat_cnt <= '0;
        end else begin
            if (aw_pop) begin
                aw_ptr <= ptr_next(aw_ptr);
            end
            if (w_ok) begin
                if (w_last) begin
                    w_beat_cnt <= '0;
                    w_ptr      <= ptr_next(w_ptr);
                end else begin
                    w_beat_cnt <= w_beat_cnt + 9'd1;
                end
            end
            if (b_ok) begin
                b_ptr <= ptr_next(b_ptr);
            end
        end
    end

    // Sticky error: stray W beat, premature B, or an error response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_err <= 1'b0;
        end else if ((w_beat && !fifo_mo_w_valid) || (b_done && !b_ok) || (b_done && b_err)) begin
            wr_err <= 1'b1;
        end
    end

endmodule

// File: doc/mo_wr_fifo.md
Name: mo_wr_fifo

Overview:
Write-direction companion of the outstanding-read splitter in the AXI DMA engine. Splits one large write request (start_addr, len in bytes) into AXI-legal bursts that never cross a 4KB boundary and never exceed 256 beats. Each burst is queued in a circular MO FIFO, which three consumer pointers read:
- AW: address issue.
- W: data beat counting and wlast generation.
- B: completion, which frees the slot.

Parameters:
NUM_MO_BUF, 4, max outstanding bursts; FIFO has NUM_MO_BUF+1 slots
ADDR_WIDTH, 64, address width (32 or 64)
DATA_WIDTH, 256, W data width in bits; beat = DATA_WIDTH/8 bytes
addr_t, axi_pkg::addr_64_t, address type
trans_t, axi_pkg::trans_64_t, burst descriptor {addr, len}; len = beat count 1..256 (AW driver subtracts 1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start_valid  in  1  large write request valid
start_ready  out  1  request accepted when start_valid && start_ready
start_addr  in  addr_t  byte address, beat-aligned
len  in  32  total bytes, multiple of beat size
mo_fifo_full  out  1  no free slot
mo_fifo_empty  out  1  no allocated slot (all B received)
fifo_mo_aw  out  trans_t  descriptor at aw_ptr
fifo_mo_aw_valid  out  1  aw_ptr != head
fifo_mo_aw_ready  in  1  AW issued
fifo_mo_w  out  trans_t  descriptor at w_ptr
fifo_mo_w_valid  out  1  w_ptr != head; W data may be driven
w_beat  in  1  one W beat transferred (wvalid && wready)
w_last  out  1  current beat is last of burst (combinational)
b_done  in  1  one B response received
b_err  in  1  bresp != OKAY, qualified by b_done
wr_err  out  1  sticky error flag
wr_busy  out  1  state != IDLE or !mo_fifo_empty

Behaviour:
- Reset values:
  - state = IDLE.
  - head, aw_ptr, w_ptr, b_ptr, w_beat_cnt, remaining, current_addr = 0.
  - fifo_mem cleared; wr_err = 0.
  - Outputs at reset: start_ready = 1, mo_fifo_empty = 1, mo_fifo_full = 0, all valids 0, wr_busy = 0.
- States:
  - IDLE -> SPLIT on start_valid && start_ready. The same cycle latches current_addr = start_addr and remaining = len.
  - SPLIT -> IDLE when remaining == 0. A request with len = 0 therefore spends one SPLIT cycle and pushes nothing.
- start_ready = (state == IDLE) && !mo_fifo_full.
- Split arithmetic (combinational in SPLIT):
  - boundary_remaining = 4096 - current_addr[11:0], 13 bits.
  - raw = min(remaining, boundary_remaining).
  - bytes = min(raw, 256 beats in bytes).
  - beats = bytes >> log2(DATA_WIDTH/8).
- Push: in SPLIT, if remaining > 0 && !mo_fifo_full:
  - fifo_mem[head] <= {current_addr, beats}; head advances with wrap at NUM_MO_BUF.
  - current_addr += bytes; remaining -= bytes.
  - Rate is one burst per cycle.
- Full/empty:
  - full = (head + 1 mod slots) == b_ptr.
  - empty = head == b_ptr.
  - A slot is held until its B response arrives.
- AW pop: fifo_mo_aw_valid && fifo_mo_aw_ready -> aw_ptr advances.
- W beat counting:
  - w_last = fifo_mo_w_valid && (w_beat_cnt == fifo_mo_w.len - 1).
  - On w_beat with !w_last: w_beat_cnt + 1.
  - On w_beat with w_last: w_beat_cnt = 0 and w_ptr advances.
  - A 1-beat burst asserts w_last on its first beat.
  - W may lead AW (AXI-legal). w_beat while !fifo_mo_w_valid is ignored and sets wr_err.
- B pop:
  - b_done with b_ptr != w_ptr and b_ptr != aw_ptr: clear the slot and advance b_ptr.
  - b_done otherwise (B before its AW/W completed) is ignored and sets wr_err.
  - b_done && b_err sets wr_err.
  - wr_err clears only on reset.
- Simultaneous events: push, AW pop, W-last pop and B pop in one cycle are all independent and all take effect. A push and a B pop in the same cycle leave the occupancy unchanged.
- Wrap-around: every pointer wraps from NUM_MO_BUF to 0 independently.
- Reset mid-operation: all pointers and state return to their reset values immediately. In-flight bursts are abandoned, and downstream must also be reset.
- Latency:
  - The first descriptor is visible on fifo_mo_aw two cycles after start acceptance (latch, then push).
  - Each descriptor is visible one cycle after its push.

Decomposition:
- axi_pkg: addr_64_t/addr_32_t, trans_64_t/trans_32_t (shared with the read splitter), and constants AXI_4K_BYTES = 4096 and AXI_MAX_BEATS = 256.
- Optional sub-module burst_split_calc: a purely combinational 4KB/256-beat calculator, reusable by the read side.

Test Plan:
1. DATA_WIDTH=256, addr 0x0F00, len 0x400 -> pushes {0x0F00,8}, then {0x1000,24}; IDLE after 2 pushes.
2. DATA_WIDTH=64, addr 0x0, len 0x1000 -> 256-beat cap binds: {0x0,256}, {0x800,256}.
3. NUM_MO_BUF=4, aw_ready=1, no b_done, 6-burst request -> exactly 4 pushes, full=1, start_ready=0. Single b_done -> fifth push next cycle.
4. Burst len 1, then len 3 with w_beat every cycle -> w_last on beats 1 and 4; w_ptr advances twice.
5. b_done before any AW issued -> ignored, wr_err=1, b_ptr unchanged. b_done with b_err=1 on a valid slot -> wr_err=1, slot freed.
6. Assert rst mid-SPLIT with 2 outstanding -> next cycle: empty=1, start_ready=1, all valids 0; a new request then completes normally.
